mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all ports.
REQ-002 Parameter DATA_W, default 32: data width of all ports.
REQ-003 Parameter XFER_W, default 2: write-transfer size field width.
REQ-004 Parameter STREAK_MAX, default 4: maximum consecutive data grants while instruction fetch waits.
REQ-005 Parameter TIMEOUT, default 255: maximum response-wait cycles before abort.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 i_req_i / i_addr_i  in  1 / ADDR_W  instruction-fetch request and read address.
REQ-009 i_gnt_o / i_rvalid_o / i_rdata_o  out  1 / 1 / DATA_W  fetch grant, response valid, response data.
REQ-010 d_req_i / d_addr_i / d_wr_i  in  1 / ADDR_W / 1  data request, address, write flag (1 = store).
REQ-011 d_wdata_i / d_transfer_i  in  DATA_W / XFER_W  store data and transfer size.
REQ-012 d_gnt_o / d_rvalid_o / d_rdata_o  out  1 / 1 / DATA_W  data grant, response valid, response data.
REQ-013 mem_req_o / mem_addr_o / mem_wr_o / mem_wdata_o / mem_transfer_o  out  1 / ADDR_W / 1 / DATA_W / XFER_W  shared memory request fields.
REQ-014 mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1 / 1 / DATA_W  memory grant, response valid (reads and writes), read data.
REQ-015 timeout_o  out  1  one-cycle pulse on response timeout.

Function
REQ-016 FSM states SHALL be IDLE and WAIT_RSP; at most one transaction is outstanding at any time.
REQ-017 In IDLE, the winner SHALL be chosen combinationally: data only -> data; instruction only -> instruction; both -> data unless streak == STREAK_MAX, then instruction.
REQ-018 In IDLE with a winner, mem_req_o SHALL be 1 and mem_addr/wr/wdata/transfer SHALL carry the winner's fields; instruction requests drive mem_wr_o=0 and mem_wdata_o/mem_transfer_o=0.
REQ-019 With no winner, or in WAIT_RSP, mem_req_o SHALL be 0 and all other mem_* outputs SHALL be 0.
REQ-020 i_gnt_o / d_gnt_o SHALL equal mem_gnt_i AND (IDLE) AND (that requester is the winner), in the same cycle; never both 1.
REQ-021 On a grant, owner SHALL be registered and the FSM SHALL go to WAIT_RSP on the next edge.
REQ-022 A requester SHALL hold its request and fields stable until granted; the arbiter SHALL NOT switch winner while mem_req_o=1 and mem_gnt_i=0 (winner latched after the first ungranted request cycle).
REQ-023 In WAIT_RSP, mem_rvalid_i SHALL produce same-cycle owner rvalid=1 and owner rdata=mem_rdata_i; the FSM returns to IDLE and may issue a new request on the following cycle.
REQ-024 Non-owner rvalid SHALL be 0; i_rdata_o/d_rdata_o SHALL be 0 whenever their rvalid is 0.
REQ-025 mem_rvalid_i in IDLE SHALL be ignored (no rvalid output).
REQ-026 Streak counter (0..STREAK_MAX): +1 on a data grant with i_req_i=1, saturating; cleared on an instruction grant or a data grant with i_req_i=0.
REQ-027 Wait counter SHALL clear on entry to WAIT_RSP and increment each WAIT_RSP cycle without mem_rvalid_i; on reaching TIMEOUT the FSM SHALL return to IDLE, pulse timeout_o for 1 cycle and pulse owner rvalid with rdata=0.
REQ-028 mem_rvalid_i in the same cycle as the timeout SHALL take precedence: normal response, no timeout_o.

Reset
REQ-029 While rst=1: state IDLE, owner=instruction, streak=0, wait counter=0, latched-winner flag clear.
REQ-030 All outputs SHALL be 0 during reset and in the first cycle after release when no request is present.
REQ-031 Assertion of rst in WAIT_RSP SHALL abandon the transaction immediately with no rvalid or timeout_o.

Verification
REQ-032 i_req=1, addr 0x100, mem_gnt=1, mem_rvalid next cycle with 0xDEADBEEF -> i_gnt=1 cycle 0; i_rvalid=1, i_rdata=0xDEADBEEF cycle 1; d_rvalid=0.
REQ-033 i_req and d_req held, mem_gnt always 1, rvalid 1 cycle after grant -> grant order D,D,D,D,I,D,D,D,D,I (STREAK_MAX=4).
REQ-034 d_req store addr 0x40, wdata 0x12345678, transfer 2, mem_gnt low 3 cycles, then high; i_req rises meanwhile -> mem_* fields stable for 4 cycles, d_gnt on 4th, no i_gnt during that window.
REQ-035 Granted data read, mem_rvalid never asserted, TIMEOUT=8 -> 8 WAIT_RSP cycles, then timeout_o=1 and d_rvalid=1 with d_rdata=0, IDLE next cycle.
REQ-036 rst pulsed in WAIT_RSP, then mem_rvalid=1 after release -> no rvalid, no timeout_o, streak=0, next request arbitrated normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port
// with a single outstanding transaction, anti-starvation streak limit and response timeout.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int XFER_W     = 2,
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_wr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [XFER_W-1:0] d_transfer_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [XFER_W-1:0] mem_transfer_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              timeout_o
);

    localparam int STREAK_W = $clog2(STREAK_MAX + 1);
    localparam int WCNT_W   = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT_RSP} state_t;

    state_t              state_reg;
    logic                owner_data_reg;
    logic [STREAK_W-1:0] streak_reg;
    logic [WCNT_W-1:0]   wait_cnt_reg;
    logic                latch_valid_reg;
    logic                latch_data_reg;

    logic in_idle, in_wait, streak_full, pick_data, win_valid, grant;
    logic rsp, tmo;

    // rst gates everything combinationally so outputs are quiet while it is held
    assign in_idle     = (state_reg == IDLE) && !rst;
    assign in_wait     = (state_reg == WAIT_RSP) && !rst;
    assign streak_full = (streak_reg == STREAK_W'(STREAK_MAX));

    // Once a request has gone out ungranted, the winner is frozen until it is granted
    assign pick_data = latch_valid_reg ? latch_data_reg
                                       : (d_req_i && !(i_req_i && streak_full));
    assign win_valid = in_idle && (pick_data ? d_req_i : i_req_i);
    assign grant     = win_valid && mem_gnt_i;

    // Timeout fires in the WAIT_RSP cycle where the counter has reached TIMEOUT
    assign rsp = in_wait && mem_rvalid_i;
    assign tmo = in_wait && !mem_rvalid_i && (wait_cnt_reg == WCNT_W'(TIMEOUT));

    always_comb begin
        mem_req_o      = win_valid;
        mem_addr_o     = '0;
        mem_wr_o       = 1'b0;
        mem_wdata_o    = '0;
        mem_transfer_o = '0;
        if (win_valid) begin
            if (pick_data) begin
                mem_addr_o     = d_addr_i;
                mem_wr_o       = d_wr_i;
                mem_wdata_o    = d_wdata_i;
                mem_transfer_o = d_transfer_i;
            end else begin
                mem_addr_o = i_addr_i;
            end
        end
    end

    assign i_gnt_o    = grant && !pick_data;
    assign d_gnt_o    = grant && pick_data;
    assign i_rvalid_o = (rsp || tmo) && !owner_data_reg;
    assign d_rvalid_o = (rsp || tmo) && owner_data_reg;
    assign i_rdata_o  = (rsp && !owner_data_reg) ? mem_rdata_i : '0;
    assign d_rdata_o  = (rsp && owner_data_reg) ? mem_rdata_i : '0;
    assign timeout_o  = tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            owner_data_reg  <= 1'b0;
            streak_reg      <= '0;
            wait_cnt_reg    <= '0;
            latch_valid_reg <= 1'b0;
            latch_data_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    latch_valid_reg <= win_valid && !mem_gnt_i;
                    latch_data_reg  <= pick_data;
                    if (grant) begin
                        state_reg      <= WAIT_RSP;
                        owner_data_reg <= pick_data;
                        wait_cnt_reg   <= '0;
                        if (pick_data && i_req_i) begin
                            if (!streak_full)
                                streak_reg <= streak_reg + STREAK_W'(1);
                        end else begin
                            streak_reg <= '0;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (rsp || tmo)
                        state_reg <= IDLE;
                    else
                        wait_cnt_reg <= wait_cnt_reg + WCNT_W'(1);
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
